// File: rtl/narrow_16to8.sv
// narrow_16to8: streaming signed word-to-byte narrowing unit with a
// 2-entry skid buffer (output register + skid register).
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   in_valid/in_ready/in_data/in_sat input stream; in_sat 1=saturate, 0=wrap
//   out_valid/out_ready/out_data/out_ovf  output byte stream + range flag
//   clr_count/ovf_count              saturating count of out-of-range accepts
//   ovf_sticky                       only with NARROW_STICKY_OVF_EN defined
module narrow_16to8 #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf,
    input  logic             clr_count,
`ifdef NARROW_STICKY_OVF_EN
    output logic             ovf_sticky,
`endif
    output logic [CNT_W-1:0] ovf_count
);

    localparam int TOP_W = IN_W - OUT_W + 1;

    logic             out_vld_q, out_vld_d;
    logic [OUT_W-1:0] out_dat_q, out_dat_d;
    logic             out_ovf_q, out_ovf_d;
    logic             skd_vld_q, skd_vld_d;
    logic [OUT_W-1:0] skd_dat_q, skd_dat_d;
    logic             skd_ovf_q, skd_ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [TOP_W-1:0] top;
    logic             ovf;
    logic             sign;
    logic [OUT_W-1:0] nar;
    logic             accept;
    logic             out_free;

    // Out of range when the bits above the byte's sign bit disagree with it.
    assign top  = in_data[IN_W-1:OUT_W-1];
    assign ovf  = !((&top) || !(|top));
    assign sign = in_data[IN_W-1];

    always_comb begin
        nar = in_data[OUT_W-1:0];
        if (in_sat && ovf) begin
            nar = {sign, {(OUT_W-1){~sign}}};
        end
    end

    // in_ready is just the skid flop, so no path from out_ready.
    assign in_ready = ~skd_vld_q;
    assign accept   = in_valid & in_ready;
    assign out_free = ~out_vld_q | out_ready;

    always_comb begin
        out_vld_d = out_vld_q;
        out_dat_d = out_dat_q;
        out_ovf_d = out_ovf_q;
        skd_vld_d = skd_vld_q;
        skd_dat_d = skd_dat_q;
        skd_ovf_d = skd_ovf_q;
        if (out_free) begin
            if (skd_vld_q) begin
                // Skid full means in_ready was low: no accept this cycle.
                out_vld_d = 1'b1;
                out_dat_d = skd_dat_q;
                out_ovf_d = skd_ovf_q;
                skd_vld_d = 1'b0;
            end else if (accept) begin
                out_vld_d = 1'b1;
                out_dat_d = nar;
                out_ovf_d = ovf;
            end else begin
                out_vld_d = 1'b0;
            end
        end else if (accept) begin
            skd_vld_d = 1'b1;
            skd_dat_d = nar;
            skd_ovf_d = ovf;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clr_count) begin
            cnt_d = '0;
        end else if (accept && ovf && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
            out_ovf_q <= 1'b0;
            skd_vld_q <= 1'b0;
            skd_dat_q <= '0;
            skd_ovf_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            out_vld_q <= out_vld_d;
            out_dat_q <= out_dat_d;
            out_ovf_q <= out_ovf_d;
            skd_vld_q <= skd_vld_d;
            skd_dat_q <= skd_dat_d;
            skd_ovf_q <= skd_ovf_d;
            cnt_q     <= cnt_d;
        end
    end

`ifdef NARROW_STICKY_OVF_EN
    logic sticky_q, sticky_d;

    always_comb begin
        sticky_d = sticky_q;
        if (clr_count) begin
            sticky_d = 1'b0;
        end else if (accept && ovf) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign ovf_sticky = sticky_q;
`endif

    assign out_valid = out_vld_q;
    assign out_data  = out_dat_q;
    assign out_ovf   = out_ovf_q;
    assign ovf_count = cnt_q;

endmodule

// File: tb/tb_narrow_16to8.sv
// tb_narrow_16to8: queue-based reference model plus directed and random
// stimulus for narrow_16to8.
module tb_narrow_16to8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_sat;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_ovf;
    logic        clr_count;
    logic [7:0]  ovf_count;
`ifdef NARROW_STICKY_OVF_EN
    logic        ovf_sticky;
`endif

    narrow_16to8 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sat    (in_sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .clr_count (clr_count),
`ifdef NARROW_STICKY_OVF_EN
        .ovf_sticky(ovf_sticky),
`endif
        .ovf_count (ovf_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] w;
        logic [7:0]  b;
        logic        o;
    } ent_t;

    ent_t q[$];
    int   m_cnt    = 0;
    bit   m_sticky = 1'b0;
    bit   mon_en   = 1'b0;
    bit   rnd_ph   = 1'b0;
    int   checks   = 0;
    int   errors   = 0;

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    function automatic ent_t model(input logic [15:0] w, input logic s);
        ent_t r;
        int   v;
        v   = int'($signed(w));
        r.w = w;
        r.o = (v > 127) || (v < -128);
        r.b = w[7:0];
        if (s && r.o) r.b = (v < 0) ? 8'h80 : 8'h7F;
        return r;
    endfunction

    // Compare DUT against the model at every negedge, then advance the
    // model to reflect what the coming posedge will do.
    always @(negedge clk) begin
        if (mon_en) begin
            bit acc, drn;
            chk("in_ready", in_ready, q.size() < 2);
            chk("out_valid", out_valid, q.size() > 0);
            chk("ovf_count", ovf_count, m_cnt);
`ifdef NARROW_STICKY_OVF_EN
            chk("ovf_sticky", ovf_sticky, m_sticky);
`endif
            if (q.size() > 0) begin
                chk("out_data", out_data, q[0].b);
                chk("out_ovf", out_ovf, q[0].o);
            end
            if (!rst_n) begin
                q.delete();
                m_cnt    = 0;
                m_sticky = 1'b0;
            end else begin
                acc = in_valid && (q.size() < 2);
                drn = out_ready && (q.size() > 0);
                if (drn) begin
                    if (rnd_ph) begin
                        chk("roundtrip", {{8{out_data[7]}}, out_data},
                            q[0].w);
                        chk("rnd_ovf", out_ovf, 1'b0);
                    end
                    void'(q.pop_front());
                end
                if (acc) q.push_back(model(in_data, in_sat));
                if (clr_count) begin
                    m_cnt    = 0;
                    m_sticky = 1'b0;
                end else if (acc && model(in_data, in_sat).o) begin
                    if (m_cnt < 255) m_cnt++;
                    m_sticky = 1'b1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] w, input logic s);
        int n = 0;
        in_valid = 1'b1;
        in_data  = w;
        in_sat   = s;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready %0b required 1", in_ready);
        end
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sat    = 1'b0;
        out_ready = 1'b1;
        clr_count = 1'b0;
        repeat (3) step();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_out_ovf", out_ovf, 1'b0);
        chk("rst_count", ovf_count, 8'd0);
        chk("rst_in_ready", in_ready, 1'b1);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Saturate mode
        send(16'h007F, 1'b1);
        chk("sat0_data", out_data, 8'h7F); chk("sat0_ovf", out_ovf, 1'b0);
        send(16'h0080, 1'b1);
        chk("sat1_data", out_data, 8'h7F); chk("sat1_ovf", out_ovf, 1'b1);
        send(16'hFF80, 1'b1);
        chk("sat2_data", out_data, 8'h80); chk("sat2_ovf", out_ovf, 1'b0);
        send(16'hFF7F, 1'b1);
        chk("sat3_data", out_data, 8'h80); chk("sat3_ovf", out_ovf, 1'b1);
        step();
        chk("sat_count", ovf_count, 8'd2);

        clr_count = 1'b1; step(); clr_count = 1'b0;
        chk("clr_count", ovf_count, 8'd0);

        // Wrap mode
        send(16'h0080, 1'b0);
        chk("wr0_data", out_data, 8'h80); chk("wr0_ovf", out_ovf, 1'b1);
        send(16'h1234, 1'b0);
        chk("wr1_data", out_data, 8'h34); chk("wr1_ovf", out_ovf, 1'b1);
        send(16'hFFFF, 1'b0);
        chk("wr2_data", out_data, 8'hFF); chk("wr2_ovf", out_ovf, 1'b0);
        step();
        chk("wr_count", ovf_count, 8'd2);

        // Backpressure
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sat    = 1'b1;
        in_data   = 16'h0001; step();
        chk("bp_d1", out_data, 8'h01); chk("bp_rdy1", in_ready, 1'b1);
        in_data   = 16'h0002; step();
        chk("bp_d2", out_data, 8'h01); chk("bp_rdy2", in_ready, 1'b0);
        in_data   = 16'h0003; step();
        chk("bp_d3", out_data, 8'h01); chk("bp_rdy3", in_ready, 1'b0);
        out_ready = 1'b1; step();
        chk("bp_o2", out_data, 8'h02); chk("bp_rdy4", in_ready, 1'b1);
        step();
        chk("bp_o3", out_data, 8'h03); chk("bp_v3", out_valid, 1'b1);
        in_valid  = 1'b0; step();
        chk("bp_empty", out_valid, 1'b0);

        // Counter saturation and clear priority
        for (int i = 0; i < 300; i++) send(16'h7FFF, 1'b1);
        step();
        chk("cnt_sat", ovf_count, 8'd255);
`ifdef NARROW_STICKY_OVF_EN
        chk("sticky_set", ovf_sticky, 1'b1);
`endif
        in_valid  = 1'b1;
        in_data   = 16'h7FFF;
        clr_count = 1'b1;
        step();
        in_valid  = 1'b0;
        clr_count = 1'b0;
        chk("clr_prio", ovf_count, 8'd0);
`ifdef NARROW_STICKY_OVF_EN
        chk("sticky_clr", ovf_sticky, 1'b0);
`endif
        step();

        // Reset with both buffers full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h7FFF; step();
        in_data   = 16'h8000; step();
        in_valid  = 1'b0;
        chk("full_rdy", in_ready, 1'b0);
        chk("full_count", ovf_count, 8'd2);
        rst_n = 1'b0; step();
        chk("mr_valid", out_valid, 1'b0);
        chk("mr_data", out_data, 8'h00);
        chk("mr_count", ovf_count, 8'd0);
        chk("mr_rdy", in_ready, 1'b1);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (3) step();
        chk("mr_nolegacy", out_valid, 1'b0);

        // Random in-range traffic
        rnd_ph = 1'b1;
        for (int i = 0; i < 600; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 16'($signed(int'($urandom_range(0, 255)) - 128));
            in_sat    = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 3) != 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
        chk("rnd_drained", out_valid, 1'b0);
        chk("rnd_count", ovf_count, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/narrow_16to8.md
Name: narrow_16to8

Overview:
- Streaming narrowing unit: the inverse of the 8-to-16 sign extender.
- Accepts signed 16-bit words and emits signed 8-bit bytes.
- Per-word mode selects saturation or two's-complement wrap; an out-of-range flag accompanies each byte.
- Sits between the datapath and the byte-wide store/IO path; valid/ready on both sides with a 2-entry skid buffer for full throughput under backpressure.

Parameters:
- IN_W, 16, input word width (signed).
- OUT_W, 8, output byte width (signed); must be < IN_W.
- CNT_W, 8, width of the overflow event counter.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  input word present.
- in_ready  output  1  unit can accept a word this cycle.
- in_data  input  IN_W  signed input word.
- in_sat  input  1  1 = saturate, 0 = wrap; sampled with in_data.
- out_valid  output  1  output byte present.
- out_ready  input  1  downstream accepts byte.
- out_data  output  OUT_W  narrowed signed byte.
- out_ovf  output  1  input for this byte was outside [-128, 127].
- clr_count  input  1  synchronous clear of ovf_count.
- ovf_count  output  CNT_W  number of accepted out-of-range words, saturating.

Behaviour:
- Reset (rst_n=0 at a clk edge): out_valid=0, out_data=0, out_ovf=0, ovf_count=0, skid buffer empty, in_ready=1 from the first cycle after reset.
- Reset mid-transfer discards all buffered bytes; no partial output.
- Range check: ovf = in_data[IN_W-1:OUT_W-1] not all equal, i.e. the top IN_W-OUT_W+1 bits differ.
- Saturate mode:
  - ovf and sign bit 0 -> 0x7F.
  - ovf and sign bit 1 -> 0x80.
  - otherwise in_data[OUT_W-1:0].
- Wrap mode: always in_data[OUT_W-1:0]; out_ovf is still reported.
- Input handshake: transfer occurs when in_valid & in_ready.
- Output handshake: transfer occurs when out_valid & out_ready.
- out_data and out_ovf are held stable while out_valid=1 and out_ready=0.
- Latency: an accepted word appears on out_data/out_valid on the next cycle when the output stage is empty or draining.
- Storage: output register plus one skid register.
- in_ready = skid register empty; it is registered, with no combinational path from out_ready.
- Backpressure: if out_ready=0 while the output register holds a byte, the next accepted word goes to the skid register and in_ready drops the following cycle.
- On drain, the skid register moves to the output register.
- Order is strictly preserved.
- Throughput: one byte per cycle while out_ready=1 continuously.
- Simultaneous accept and drain with skid empty: the output register is replaced by the new byte; no bubble.
- Counter: increments by 1 on each accepted word with ovf=1, counted at input acceptance, not output.
  - Saturates at 2^CNT_W-1; no wrap.
  - clr_count=1 forces 0 and has priority over a same-cycle increment (that event is not counted).
- Unchanged signals: in_valid=0 or in_ready=0 changes neither the buffers nor the counter.
- Round-trip property: for in-range input, sign-extending out_data back to 16 bits reproduces in_data in both modes.

Optional Feature:
- Macro: NARROW_STICKY_OVF_EN.
- When defined:
  - Extra output port ovf_sticky (1 bit), reset 0.
  - Set on the cycle after any accepted word with ovf=1.
  - Cleared only by rst_n or clr_count.
  - clr_count wins over a same-cycle set.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Saturate mode, out_ready=1, inputs 0x007F, 0x0080, 0xFF80, 0xFF7F -> out_data 0x7F, 0x7F, 0x80, 0x80 and out_ovf 0, 1, 0, 1; each appears 1 cycle after acceptance; ovf_count=2.
- Wrap mode, inputs 0x0080, 0x1234, 0xFFFF -> out_data 0x80, 0x34, 0xFF and out_ovf 1, 1, 0; ovf_count=2.
- Backpressure:
  - Stimulus: out_ready=0, stream 0x0001, 0x0002, 0x0003 with in_valid held.
  - Response: first two accepted; in_ready=0 before the third; out_data holds 0x01.
  - Release out_ready=1 -> 0x01, 0x02, 0x03 emitted in order on consecutive cycles with no loss or duplication.
- Counter saturation:
  - Stimulus: 300 overflowing words (0x7FFF).
  - Response: ovf_count stops at 255; NARROW_STICKY_OVF_EN build shows ovf_sticky=1.
  - clr_count asserted in the same cycle as an overflowing accept -> ovf_count=0 (and ovf_sticky=0 in that build).
- Reset mid-operation: both buffers full, rst_n=0 for 1 cycle -> out_valid=0, out_data=0, ovf_count=0; in_ready=1 the next cycle; old bytes are never emitted.
- Random in-range words (-128..127), random in_sat, random out_ready -> sign-extended out_data equals in_data for every byte; out_ovf=0 throughout.
